// File: rtl/key_event_pkg.sv
// Shared types and helpers for the front-panel key event generator.
package key_event_pkg;

  // Debounce/repeat timebase: one tick per millisecond.
  localparam int unsigned TICK_HZ = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_DB
  } key_fsm_e;

  // Counter width for the largest interval; the counter only ever holds 0..max-1.
  function automatic int unsigned cnt_width(input int unsigned debounce_ms,
                                            input int unsigned delay_ms,
                                            input int unsigned rate_ms);
    int unsigned max_v;
    max_v = debounce_ms;
    if (delay_ms > max_v) max_v = delay_ms;
    if (rate_ms > max_v) max_v = rate_ms;
    return (max_v < 2) ? 1 : $clog2(max_v);
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// Per-key synchroniser, debounce FSM and interval counter.
// Build option: KEY_EVENT_REPEAT_EN enables the auto-repeat state and pulse.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   tick           - 1 ms strobe shared by all keys
//   key            - raw key, active-low, asynchronous to clk
//   key_state      - debounced level (0 = pressed)
//   press_pulse    - one cycle on an accepted press
//   release_pulse  - one cycle on an accepted release
//   repeat_pulse   - one cycle per auto-repeat (tied 0 without the option)
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);

  logic             sync1_q;
  logic             sync2_q;
  key_fsm_e         state_q;
  key_fsm_e         state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             key_state_d;
  logic             press_d;
  logic             release_d;
`ifdef KEY_EVENT_REPEAT_EN
  logic             repeat_q;
  logic             repeat_d;
`endif

  // Two-flop synchroniser; idles released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_state     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_state     <= key_state_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q      <= repeat_d;
`endif
    end
  end

  // Next state; an interval completes on the tick that would bring cnt to its target.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_state_d = key_state;
    press_d     = 1'b0;
    release_d   = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    repeat_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_PRESS_DB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
            state_d     = ST_HELD;
            cnt_d       = '0;
            key_state_d = 1'b0;
            press_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HELD: begin
        if (sync2_q) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (tick) begin
          if (cnt_q == CNT_W'(REPEAT_DELAY_MS - 1)) begin
            state_d  = ST_REPEAT;
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
`ifdef KEY_EVENT_REPEAT_EN
      ST_REPEAT: begin
        if (sync2_q) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(REPEAT_RATE_MS - 1)) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      ST_RELEASE_DB: begin
        // A re-press during release debounce resumes the hold with fresh repeat timing.
        if (!sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            key_state_d = 1'b1;
            release_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_EVENT_REPEAT_EN
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_event_gen.sv
// Front-panel key input stage: shared 1 ms prescaler plus one debounce FSM per key.
// Build option: KEY_EVENT_REPEAT_EN enables auto-repeat pulses.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   key            - raw keys, active-low, asynchronous to clk
//   key_state      - debounced levels (0 = pressed)
//   press_pulse    - one-cycle pulse per accepted press
//   release_pulse  - one-cycle pulse per accepted release
//   repeat_pulse   - one-cycle pulse per auto-repeat
//   any_pressed    - high while any debounced key is pressed
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned N_KEYS          = 6,
  parameter int unsigned F_CLK           = 50000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_pressed
);

  localparam int unsigned DIV   = F_CLK / TICK_HZ;
  localparam int unsigned PRE_W = (DIV < 2) ? 1 : $clog2(DIV);

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  // Terminal-count strobe; with DIV == 1 the counter sits at 0 and ticks every cycle.
  assign tick = (pre_q == PRE_W'(DIV - 1));

  // Millisecond prescaler, 0..DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // One independent debounce FSM per key.
  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    key_event_fsm #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .key           (key[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // Pure OR of the registered levels, so it tracks key_state in the same cycle.
  assign any_pressed = |(~key_state);

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Upstream input stage for the front-panel keys; replaces per-key debounce instances in front of frequency/control logic.
- Synchronises N raw active-low keys, debounces them on a shared 1 ms tick, and emits a debounced level plus single-cycle press, release and auto-repeat pulses per key.
- Downstream logic consumes the debounced level (low = pressed) or the pulses directly on `clk`.

Parameters:
- N_KEYS, 6, number of keys.
- F_CLK, 50000000, input clock frequency in Hz. Must be ≥1000 and a multiple of 1000.
- DEBOUNCE_MS, 20, stable time required to accept a press or release, in ticks.
- REPEAT_DELAY_MS, 500, hold time before the first repeat pulse, in ticks.
- REPEAT_RATE_MS, 100, period between subsequent repeat pulses, in ticks.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key, input, N_KEYS, raw keys, active-low, asynchronous to clk.
- key_state, output, N_KEYS, debounced level: 0 = pressed, 1 = released.
- press_pulse, output, N_KEYS, one-cycle pulse on an accepted press.
- release_pulse, output, N_KEYS, one-cycle pulse on an accepted release.
- repeat_pulse, output, N_KEYS, one-cycle pulse for each auto-repeat.
- any_pressed, output, 1, OR of all bits of ~key_state.

Behaviour:
- **Clock and reset.** One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- **Reset values.**
  - Sync flops: all 1.
  - key_state: all 1.
  - press_pulse, release_pulse, repeat_pulse: all 0.
  - any_pressed: 0.
  - Prescaler: 0. Every per-key FSM: IDLE with its counter at 0.
- **Synchroniser.** Two flops per key. The FSM sees `key` with 2-cycle latency.
- **Tick prescaler.**
  - Counter runs 0..F_CLK/1000-1 and wraps.
  - `tick` is high for exactly one cycle when the counter is at its terminal value.
  - If F_CLK=1000, `tick` is high every cycle.
- **Per-key FSM states:** IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB. One counter per key, wide enough for max(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS).
  - IDLE: on synced key = 0, go to PRESS_DB and set cnt=0.
  - PRESS_DB:
    - Synced key = 1 on any cycle: go back to IDLE (bounce rejected, no pulse).
    - On tick: cnt++.
    - When cnt reaches DEBOUNCE_MS: go to HELD, drive key_state=0, pulse press_pulse, set cnt=0.
  - HELD:
    - Synced key = 1: go to RELEASE_DB, set cnt=0.
    - Otherwise cnt++ on each tick. At REPEAT_DELAY_MS: go to REPEAT, pulse repeat_pulse, set cnt=0.
  - REPEAT:
    - Synced key = 1: go to RELEASE_DB, set cnt=0.
    - Otherwise cnt++ on each tick. At REPEAT_RATE_MS: pulse repeat_pulse, set cnt=0, stay in REPEAT.
  - RELEASE_DB:
    - Synced key = 0 on any cycle: go to HELD with cnt=0. No pulse; key_state stays 0.
    - On tick: cnt++.
    - When cnt reaches DEBOUNCE_MS: go to IDLE, drive key_state=1, pulse release_pulse.
- **Output timing.** All outputs are registered and change in the cycle after the qualifying tick.
- **Debounce tolerance.** Effective debounce time lies between (DEBOUNCE_MS-1) and DEBOUNCE_MS ms, depending on tick phase.
- **Pulse exclusivity.** At most one of press/release/repeat pulses per key per cycle. Pulses never last more than 1 cycle.
- **Key independence.** Keys are fully independent. Simultaneous presses on several keys produce pulses in the same cycle.
- **Mid-operation reset.** Reset returns all keys to IDLE immediately. No release_pulse is generated. After reset, a key held low is re-debounced from IDLE.

Optional Feature:
- Macro: KEY_EVENT_REPEAT_EN.
- Defined: the REPEAT state and repeat_pulse behave as above.
- Undefined:
  - The REPEAT state and repeat logic are not compiled.
  - HELD waits only for release, and cnt is not advanced in HELD.
  - repeat_pulse is tied to 0.
  - REPEAT_DELAY_MS and REPEAT_RATE_MS are ignored.

Decomposition:
- Package `key_event_pkg`:
  - enum typedef `key_fsm_e` holding the five states;
  - localparam TICK_HZ=1000;
  - function computing the counter width from the three ms parameters.
- Sub-module `key_event_fsm`:
  - one instance per key via generate;
  - contains the synchroniser, FSM and counter;
  - inputs: clk, rst_n, tick, raw key;
  - outputs: the level and the three pulses.
- Top level holds the shared prescaler and the any_pressed OR.

Test Plan:
All scenarios use F_CLK=10000 (tick every 10 cycles), DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2.
- **Reset state.** Assert rst_n low with key=all 0 → key_state=6'h3F, all pulses 0, any_pressed=0. Release reset and hold key[0]=0 → press_pulse[0] exactly once, 21–32 cycles later.
- **Bounce rejection.** Toggle key[2] low for 15 cycles, high for 5, repeated 4 times → no pulses; key_state[2] stays 1.
- **Press, repeat, release.** Hold key[0] low for 150 cycles, then release → press_pulse[0]=1 once; first repeat_pulse[0] 50±10 cycles after press; then repeats every 20 cycles; one release_pulse[0] 21–32 cycles after release; key_state[0] returns to 1.
- **Release glitch.** While holding key[5], release for 15 cycles, then press again → no release_pulse[5], no second press_pulse[5]; repeat timing restarts from HELD.
- **Simultaneous presses with mid-operation reset.** Press key[0] and key[5] simultaneously → both press pulses in the same cycle and any_pressed=1. Pulse rst_n low mid-hold → key_state=all 1 within the same cycle and no release pulses.
- **Repeat macro undefined.** Rebuild without KEY_EVENT_REPEAT_EN and hold key[1] for 200 cycles → repeat_pulse[1] stays 0; press and release pulses unchanged.
